// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the priority-encoder display path:
// segment glyph table, priority index and binary-to-BCD conversion.
package prio_enc_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} glyphs for the numerals 0..9
  localparam logic [6:0] GLYPH [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam int BCD_MAX = 16;

  function automatic logic [5:0] prio_idx(input logic [63:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    return (nib < 4'd10) ? GLYPH[nib] : SEG_BLANK;
  endfunction

  // Double-dabble; only the lowest ndig nibbles are corrected
  function automatic logic [4*BCD_MAX-1:0] bin2bcd(input logic [5:0] bin, input int ndig);
    logic [4*BCD_MAX-1:0] bcd;
    bcd = '0;
    for (int i = 5; i >= 0; i--) begin
      for (int d = 0; d < BCD_MAX; d++) begin
        if (d < ndig && bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[4*BCD_MAX-2:0], bin[i]};
    end
    return bcd;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed active-low 7-segment scanner with leading-zero blanking;
// an and seg are registered together from the same digit index.
module seg_scan
  import prio_enc_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] bcd,
  input  logic                blank,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(SCAN_DIV);

  logic [SW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [3:0]    w_nib;
  logic          w_dblank;

  always_comb begin
    logic zeros;
    zeros    = 1'b1;
    w_nib    = 4'd0;
    w_dblank = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      zeros = zeros && (bcd[4*d +: 4] == 4'd0);
      if (int'(r_idx) == d) begin
        w_nib    = bcd[4*d +: 4];
        w_dblank = zeros && (d != 0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      an    <= ~DIGITS'(1);
      seg   <= SEG_BLANK;
    end else begin
      if (r_cnt == SW'(SCAN_DIV - 1)) begin
        r_cnt <= '0;
        r_idx <= (int'(r_idx) == DIGITS - 1) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      an  <= ~(DIGITS'(1) << r_idx);
      seg <= (blank || w_dblank) ? SEG_BLANK : glyph(w_nib);
    end
  end

endmodule

// File: rtl/prio_enc_scan.sv
// Registered priority encoder feeding a multiplexed decimal display.
// Define PRIO_ENC_HOLD_EN to hold the last non-zero code when the input idles.
module prio_enc_scan
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DIGITS   = 2,
  parameter  int SCAN_DIV = 1000,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  sw,
  input  logic              enable,
  output logic              indicator,
  output logic [CW-1:0]     code,
  output logic              chg,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  logic [WIDTH-1:0]    r_sw_p0, r_sw_p1;
  logic                r_en_p0, r_en_p1;
  logic [CW-1:0]       r_code_p2;
  logic                r_ind_p2, r_chg_p2;
  logic [WIDTH-1:0]    w_gated;
  logic                w_any;
  logic [CW-1:0]       w_code_nxt;
  logic [4*DIGITS-1:0] w_bcd;
  logic                w_blank;

  // p0/p1: two-flop synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_p0 <= '0;
      r_en_p0 <= 1'b0;
      r_sw_p1 <= '0;
      r_en_p1 <= 1'b0;
    end else begin
      r_sw_p0 <= sw;
      r_en_p0 <= enable;
      r_sw_p1 <= r_sw_p0;
      r_en_p1 <= r_en_p0;
    end
  end

  assign w_gated = r_sw_p1 & {WIDTH{r_en_p1}};
  assign w_any   = |w_gated;

`ifdef PRIO_ENC_HOLD_EN
  logic r_held_p2;
  assign w_code_nxt = w_any ? CW'(prio_idx(64'(w_gated))) : r_code_p2;
  assign w_blank    = ~r_held_p2;

  always_ff @(posedge clk) begin
    if (rst)        r_held_p2 <= 1'b0;
    else if (w_any) r_held_p2 <= 1'b1;
  end
`else
  assign w_code_nxt = CW'(prio_idx(64'(w_gated)));
  assign w_blank    = ~r_ind_p2;
`endif

  // p2: encode and change detect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code_p2 <= '0;
      r_ind_p2  <= 1'b0;
      r_chg_p2  <= 1'b0;
    end else begin
      r_code_p2 <= w_code_nxt;
      r_ind_p2  <= w_any;
      r_chg_p2  <= (w_code_nxt != r_code_p2) || (w_any != r_ind_p2);
    end
  end

  assign code      = r_code_p2;
  assign indicator = r_ind_p2;
  assign chg       = r_chg_p2;

  assign w_bcd = (4*DIGITS)'(bin2bcd(6'(r_code_p2), DIGITS));

  seg_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk   (clk),
    .rst   (rst),
    .bcd   (w_bcd),
    .blank (w_blank),
    .an    (an),
    .seg   (seg)
  );

endmodule

// File: tb/tb_prio_enc_scan.sv
// Bench for prio_enc_scan (WIDTH=16, DIGITS=2, SCAN_DIV=4): edge-indexed
// behavioural model compared every cycle, plus hand-computed expectations.
module tb_prio_enc_scan;

  localparam int W = 16, D = 2, S = 4, CW = 4, MAXE = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [W-1:0]  sw = '0;
  logic          indicator, chg;
  logic [CW-1:0] code;
  logic [6:0]    seg;
  logic [D-1:0]  an;

  prio_enc_scan #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(S)) dut (
    .clk(clk), .rst(rst), .sw(sw), .enable(enable),
    .indicator(indicator), .code(code), .chg(chg), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs as seen by each rising edge
  logic         s_rst = 1'b0, s_en = 1'b0;
  logic [W-1:0] s_sw = '0;
  int           pe_cnt = 0, lr_pe = -1000;
  always @(posedge clk) begin
    s_rst  <= rst;
    s_en   <= enable;
    s_sw   <= sw;
    pe_cnt <= pe_cnt + 1;
    if (rst) lr_pe <= pe_cnt + 1;
  end

  int gl [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
  int ghist[MAXE], ecode[MAXE], eind[MAXE], evalid[MAXE];

  // Model: output after edge n depends on the gated input seen at edge n-2
  initial begin
    int n, lr, g, c, ind, val, ch, k, idx, eanv, esegv, cv;
    bit hold, blank;
`ifdef PRIO_ENC_HOLD_EN
    hold = 1'b1;
`else
    hold = 1'b0;
`endif
    n = 0; lr = -1000;
    forever begin
      @(negedge clk);
      n++;
      if (n >= MAXE) begin
        $display("FAIL model_overflow: got %0d expected below %0d", n, MAXE);
        $fatal(1, "run too long");
      end
      g = s_en ? int'(s_sw) : 0;
      ghist[n] = g;
      if (s_rst) lr = n;
      if (n - lr <= 2) begin
        c = 0; ind = 0; val = 0;
      end else if (ghist[n-2] != 0) begin
        ind = 1; val = 1; c = $clog2(ghist[n-2] + 1) - 1;
      end else begin
        ind = 0;
        c   = hold ? ecode[n-1] : 0;
        val = hold ? evalid[n-1] : 0;
      end
      ecode[n] = c; eind[n] = ind; evalid[n] = val;
      ch = (!s_rst && (c != ecode[n-1] || ind != eind[n-1])) ? 1 : 0;
      if (s_rst) begin
        eanv = 'b10; esegv = 'h7F;
      end else begin
        k     = (n - 1) - lr;
        idx   = (k / S) % D;
        eanv  = (~(1 << idx)) & 3;
        cv    = ecode[n-1];
        blank = hold ? (evalid[n-1] == 0) : (eind[n-1] == 0);
        if (blank || (idx > 0 && cv < 10 ** idx)) esegv = 'h7F;
        else esegv = gl[(cv / (10 ** idx)) % 10];
      end
      if (lr > 0) begin
        chk("m_code", 32'(code), 32'(c));
        chk("m_indicator", 32'(indicator), 32'(ind));
        chk("m_chg", 32'(chg), 32'(ch));
        chk("m_an", 32'(an), 32'(eanv));
        chk("m_seg", 32'(seg), 32'(esegv));
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_an(input logic [D-1:0] t);
    for (int i = 0; i < 40 && an !== t; i++) @(negedge clk);
    chk("wait_an", 32'(an), 32'(t));
  endtask

  logic [W-1:0] fast [8] = '{16'h0001, 16'h0300, 16'h0000, 16'h8001, 16'h0040, 16'h0041, 16'h0000, 16'h1000};

  initial begin
    step(2);
    chk("rst_code", 32'(code), 32'h0);
    chk("rst_ind", 32'(indicator), 32'h0);
    chk("rst_chg", 32'(chg), 32'h0);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'h2);
    rst = 1'b0;

    sw = 16'h002C; enable = 1'b1;
    step(3);
    chk("enc_code5", 32'(code), 32'h5);
    chk("enc_ind", 32'(indicator), 32'h1);
    chk("enc_chg_pulse", 32'(chg), 32'h1);
    step(1);
    chk("enc_chg_end", 32'(chg), 32'h0);
    wait_an(2'b10);
    chk("dig0_five", 32'(seg), 32'h12);
    wait_an(2'b01);
    chk("dig1_blank", 32'(seg), 32'h7F);

    sw = 16'hFFFF; enable = 1'b0;
    step(3);
    chk("gate_ind", 32'(indicator), 32'h0);
`ifdef PRIO_ENC_HOLD_EN
    chk("gate_code_held", 32'(code), 32'h5);
`else
    chk("gate_code", 32'(code), 32'h0);
    step(1);
    chk("gate_blank", 32'(seg), 32'h7F);
`endif
    enable = 1'b1;
    step(3);
    chk("ungate_code", 32'(code), 32'hF);

    sw = 16'h8000;
    step(3);
    chk("msb_code", 32'(code), 32'hF);
    wait_an(2'b10);
    chk("msb_dig0", 32'(seg), 32'h12);
    wait_an(2'b01);
    chk("msb_dig1", 32'(seg), 32'h79);

    sw = 16'h0001;
    step(3);
    chk("lsb_code", 32'(code), 32'h0);
    chk("lsb_ind", 32'(indicator), 32'h1);
    sw = 16'h0400;
    step(12);
    sw = 16'h0000;
    step(6);
    for (int i = 0; i < 8; i++) begin
      sw = fast[i];
      step(1);
    end
    step(10);

`ifdef PRIO_ENC_HOLD_EN
    sw = 16'h0008;
    step(4);
    sw = 16'h0000;
    step(4);
    chk("hold_code", 32'(code), 32'h3);
    chk("hold_ind", 32'(indicator), 32'h0);
    wait_an(2'b10);
    chk("hold_seg", 32'(seg), 32'h30);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("hold_rst_code", 32'(code), 32'h0);
    step(1);
    chk("hold_rst_seg", 32'(seg), 32'h7F);
`endif

    // Reset landing on the edge where a scan wrap and a code change coincide
    sw = 16'h0100;
    step(6);
    for (int i = 0; i < 3 * S && ((pe_cnt + 3 - lr_pe) % S) != 0; i++) step(1);
    chk("align_wrap", 32'((pe_cnt + 3 - lr_pe) % S), 32'h0);
    sw = 16'h0002;
    step(2);
    rst = 1'b1;
    step(1);
    chk("rstwrap_chg", 32'(chg), 32'h0);
    chk("rstwrap_code", 32'(code), 32'h0);
    chk("rstwrap_an", 32'(an), 32'h2);
    chk("rstwrap_seg", 32'(seg), 32'h7F);
    rst = 1'b0;
    step(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
